control_sequencer: RTL



---
 rtl/control_sequencer_if.sv | 40 ++++
 rtl/control_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the ALU datapath system.
// The master side drives every datapath control; the slave side returns IR and flags.
interface control_sequencer_if;
    logic [15:0] IR_Out;
    logic [3:0]  ALU_Flags;
    logic [2:0]  RF_O1Sel;
    logic [2:0]  RF_O2Sel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel;
    logic [3:0]  RF_TSel;
    logic [3:0]  ALU_FunSel;
    logic [1:0]  ARF_OutASel;
    logic [1:0]  ARF_OutBSel;
    logic [1:0]  ARF_FunSel;
    logic [3:0]  ARF_RSel;
    logic        IR_LH;
    logic        IR_Enable;
    logic [1:0]  IR_FunSel;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        MuxCSel;

    modport master (
        input  IR_Out, ALU_Flags,
        output RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
               ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
               IR_LH, IR_Enable, IR_FunSel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel
    );

    modport slave (
        output IR_Out, ALU_Flags,
        input  RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
               ARF_OutASel, ARF_OutBSel, ARF_FunSel, ARF_RSel,
               IR_LH, IR_Enable, IR_FunSel, Mem_WR, Mem_CS,
               MuxASel, MuxBSel, MuxCSel
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the ALU datapath: 16 opcodes,
// two-byte fetch, up to three execute cycles, Z flag latched on ALU ops.
module control_sequencer #(
    parameter logic [7:0] INIT_PC = 8'h00
) (
    input  logic                       Clock,
    input  logic                       Reset,
    control_sequencer_if.master        bus,
    output logic [2:0]                 State,
    output logic                       Halted
);

    typedef enum logic [2:0] {
        INIT = 3'd0, F0 = 3'd1, F1 = 3'd2, F2 = 3'd3,
        E0   = 3'd4, E1 = 3'd5, E2 = 3'd6, HALT = 3'd7
    } state_t;

    state_t      state, state_nxt;
    logic        z_latch, z_nxt;
    logic [3:0]  op;
    logic [1:0]  rd, rs;
    logic [3:0]  rd_onehot;
    logic [2:0]  rd_osel, rs_osel;
    logic        is_alu;
    logic [3:0]  alu_code;

    assign op        = bus.IR_Out[15:12];
    assign rd        = bus.IR_Out[11:10];
    assign rs        = bus.IR_Out[9:8];
    assign rd_onehot = 4'b1000 >> rd;
    assign rd_osel   = {1'b1, rd};
    assign rs_osel   = {1'b1, rs};
    assign is_alu    = op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE};

    always_comb begin
        case (op)
            4'h4:    alu_code = 4'b0100;
            4'h5:    alu_code = 4'b0101;
            4'h6:    alu_code = 4'b0111;
            4'h7:    alu_code = 4'b1000;
            4'h8:    alu_code = 4'b1010;
            4'hE:    alu_code = 4'b0001;
            default: alu_code = 4'b0000;
        endcase
    end

    // NOTE: async reset drops straight into INIT, so an aborted store never reaches Mem_WR.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= INIT;
            z_latch <= 1'b0;
        end else begin
            state   <= state_nxt;
            z_latch <= z_nxt;
        end
    end

    // NOTE: every output gets its idle value first, so no path can infer a latch.
    always_comb begin
        state_nxt       = state;
        z_nxt           = z_latch;
        bus.RF_O1Sel    = 3'b000;
        bus.RF_O2Sel    = 3'b000;
        bus.RF_FunSel   = 2'b00;
        bus.RF_RSel     = 4'b0000;
        bus.RF_TSel     = 4'b0000;
        bus.ALU_FunSel  = 4'b0000;
        bus.ARF_OutASel = 2'b00;
        bus.ARF_OutBSel = 2'b00;
        bus.ARF_FunSel  = 2'b00;
        bus.ARF_RSel    = 4'b0000;
        bus.IR_LH       = 1'b0;
        bus.IR_Enable   = 1'b0;
        bus.IR_FunSel   = 2'b00;
        bus.Mem_WR      = 1'b0;
        bus.Mem_CS      = 1'b1;
        bus.MuxASel     = 2'b00;
        bus.MuxBSel     = 2'b00;
        bus.MuxCSel     = 1'b0;
        Halted          = 1'b0;

        case (state)
            INIT: begin
                bus.RF_RSel    = 4'b1111;
                bus.RF_TSel    = 4'b1111;
                bus.ARF_RSel   = 4'b1111;
                bus.IR_Enable  = 1'b1;
                // A nonzero start address is loaded instead of cleared.
                if (INIT_PC != 8'h00) begin
                    bus.ARF_FunSel = 2'b01;
                    bus.MuxBSel    = 2'b10;
                end
                state_nxt = F0;
            end
            F0: begin
                bus.ARF_OutBSel = 2'b11;
                state_nxt       = F1;
            end
            F1, F2: begin
                bus.Mem_CS      = 1'b0;
                bus.IR_Enable   = 1'b1;
                bus.IR_FunSel   = 2'b01;
                bus.IR_LH       = (state == F2);
                bus.ARF_FunSel  = 2'b10;
                bus.ARF_RSel    = 4'b1000;
                bus.ARF_OutBSel = 2'b11;
                state_nxt       = (state == F1) ? F2 : E0;
            end
            E0: begin
                state_nxt = F0;
                case (op)
                    4'h1: begin
                        bus.MuxASel   = 2'b10;
                        bus.RF_FunSel = 2'b01;
                        bus.RF_RSel   = rd_onehot;
                    end
                    4'h9, 4'hA: begin
                        bus.RF_FunSel = (op == 4'h9) ? 2'b11 : 2'b10;
                        bus.RF_RSel   = rd_onehot;
                    end
                    4'hB, 4'hC, 4'hD: begin
                        if (op == 4'hB || (op == 4'hC && z_latch) || (op == 4'hD && !z_latch)) begin
                            bus.MuxBSel    = 2'b10;
                            bus.ARF_FunSel = 2'b01;
                            bus.ARF_RSel   = 4'b1000;
                        end
                    end
                    4'h2, 4'h3: begin
                        bus.MuxBSel    = 2'b10;
                        bus.ARF_FunSel = 2'b01;
                        bus.ARF_RSel   = 4'b0100;
                        if (op == 4'h3) bus.RF_O1Sel = rd_osel;
                        state_nxt = E1;
                    end
                    4'hF: state_nxt = HALT;
                    default: begin
                        if (is_alu) begin
                            bus.RF_O1Sel = rd_osel;
                            bus.RF_O2Sel = rs_osel;
                            state_nxt    = E1;
                        end
                    end
                endcase
            end
            E1: begin
                state_nxt = F0;
                if (op == 4'h2) begin
                    bus.Mem_CS    = 1'b0;
                    bus.MuxASel   = 2'b01;
                    bus.RF_FunSel = 2'b01;
                    bus.RF_RSel   = rd_onehot;
                end else if (op == 4'h3) begin
                    bus.RF_O1Sel = rd_osel;
                    state_nxt    = E2;
                end else if (is_alu) begin
                    bus.RF_O1Sel   = rd_osel;
                    bus.RF_O2Sel   = rs_osel;
                    bus.ALU_FunSel = alu_code;
                    state_nxt      = E2;
                end
            end
            E2: begin
                state_nxt = F0;
                if (op == 4'h3) begin
                    bus.Mem_CS = 1'b0;
                    bus.Mem_WR = 1'b1;
                end else if (is_alu) begin
                    bus.RF_O1Sel   = rd_osel;
                    bus.RF_O2Sel   = rs_osel;
                    bus.ALU_FunSel = alu_code;
                    bus.RF_FunSel  = 2'b01;
                    bus.RF_RSel    = rd_onehot;
                    z_nxt          = bus.ALU_Flags[3];
                end
            end
            HALT: Halted = 1'b1;
            default: state_nxt = INIT;
        endcase
    end

    assign State = state;

endmodule
